// File: rtl/uart_rx.sv
// 8N1 serial receiver: 16x oversampling, start/stop validation, valid/read buffer.
// Optional macro UART_RX_FIFO_EN replaces the holding register with a FIFO_DEPTH-entry FIFO.
module uart_rx #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_i,
  input  logic       uart_rx_i,
  input  logic       rx_rd_i,
  output logic [7:0] rx_dat_o,
  output logic       rx_valid_o,
  output logic       rx_ferr_o,
  output logic       rx_ovr_o
);

  localparam logic [31:0] TICK_INC = 32'(BAUD * 16);
  localparam logic [31:0] TICK_LIM = 32'(CLK_HZ);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx: FIFO_DEPTH must be a power of two and at least 2");
  end

  logic        sync1_q, rxs_q;
  logic [31:0] acc_q, acc_d, acc_sum_s;
  logic        tick_q, tick_d;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        push_s, full_s;

  // Two-flop synchronizer, idles high so reset does not look like a start bit
  always_ff @(negedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= uart_rx_i;
      rxs_q   <= sync1_q;
    end
  end

  // Fractional baud accumulator producing the 16x oversampling tick
  always_comb begin
    acc_sum_s = acc_q + TICK_INC;
    if (acc_sum_s >= TICK_LIM) begin
      acc_d  = acc_sum_s - TICK_LIM;
      tick_d = 1'b1;
    end else begin
      acc_d  = acc_sum_s;
      tick_d = 1'b0;
    end
  end

  // Frame FSM next-state: ticks are counted per state, the counter restarts on every transition
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push_s  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = 4'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tick_q && cnt_q == 4'd7) begin
          cnt_d = 4'd0;
          bit_d = 3'd0;
          if (!rxs_q) begin
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else if (tick_q) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_DATA: begin
        if (tick_q && cnt_q == 4'd15) begin
          cnt_d          = 4'd0;
          shift_d[bit_q] = rxs_q;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else if (tick_q) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_STOP: begin
        if (tick_q && cnt_q == 4'd15) begin
          cnt_d = 4'd0;
          if (rxs_q) begin
            push_s  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else if (tick_q) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_WAIT_HIGH: begin
        if (rxs_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_HIGH;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Overrun is set by a dropped push and cleared by any read
  always_comb begin
    if (push_s && full_s && !rx_rd_i) begin
      ovr_d = 1'b1;
    end else if (rx_rd_i) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Tick generator, FSM and status flags
  always_ff @(negedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      acc_q   <= 32'd0;
      tick_q  <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      tick_q  <= tick_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_ferr_o = ferr_q;
  assign rx_ovr_o  = ovr_q;

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [7:0]  mem_d [FIFO_DEPTH];
  logic        empty_s, rd_s, wr_s;

  assign empty_s = (wptr_q == rptr_q);
  assign full_s  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_s    = rx_rd_i && !empty_s;
  assign wr_s    = push_s && (!full_s || rd_s);

  // FIFO pointer and storage update; a read frees the slot a same-cycle push may take
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_s) begin
      mem_d[wptr_q[AW-1:0]] = shift_q;
      wptr_d                = wptr_q + (AW+1)'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (rd_s) begin
      rptr_d = rptr_q + (AW+1)'(1);
    end else begin
      rptr_d = rptr_q;
    end
  end

  // FIFO registers
  always_ff @(negedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

  assign rx_dat_o   = mem_q[rptr_q[AW-1:0]];
  assign rx_valid_o = !empty_s;
`else
  logic [7:0] dat_q, dat_d;
  logic       valid_q, valid_d, rd_s;

  assign full_s = valid_q;
  assign rd_s   = rx_rd_i && valid_q;

  // Holding register: data stays put after a read, only valid drops
  always_comb begin
    dat_d   = dat_q;
    valid_d = valid_q;
    if (push_s && (!valid_q || rd_s)) begin
      dat_d   = shift_q;
      valid_d = 1'b1;
    end else if (rd_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Holding register flops
  always_ff @(negedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      dat_q   <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      dat_q   <= dat_d;
      valid_q <= valid_d;
    end
  end

  assign rx_dat_o   = dat_q;
  assign rx_valid_o = valid_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx; runs the receiver at a 20 MHz clock so the
// bit period is ~174 clocks and the whole run stays short.
module tb_uart_rx;

  localparam int CLK_HZ = 20_000_000;
  localparam int BIT    = 174;
  localparam int BIT_HI = BIT * 97 / 100;
  localparam int BIT_LO = BIT * 103 / 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] rx_dat_o;
  logic       rx_valid_o, rx_ferr_o, rx_ovr_o;

  int n_cmp = 0;
  int n_err = 0;
  int ferr_cnt = 0;
  int ferr_base;
  int rise_off;
  bit b2b_got;
  logic [7:0] b2b_exp [2] = '{8'hA5, 8'h3C};

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(115200), .FIFO_DEPTH(8)) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .uart_rx_i (line),
    .rx_rd_i   (rd),
    .rx_dat_o  (rx_dat_o),
    .rx_valid_o(rx_valid_o),
    .rx_ferr_o (rx_ferr_o),
    .rx_ovr_o  (rx_ovr_o)
  );

  always #5 clk = ~clk;

  // DUT flops move on the falling edge, so each ferr pulse is seen on exactly one rising edge
  always @(posedge clk) begin
    if (rx_ferr_o) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sends one 8N1 frame; rise_off records the stop-bit clock at which valid first appears
  task automatic send_byte(input logic [7:0] b, input int bclk, input logic stop_v);
    rise_off = -1;
    line = 1'b0;
    repeat (bclk) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      repeat (bclk) @(posedge clk);
    end
    line = stop_v;
    for (int i = 0; i < bclk; i++) begin
      @(posedge clk);
      if (rx_valid_o && rise_off < 0) rise_off = i;
    end
    line = 1'b1;
  endtask

  task automatic pulse_rd();
    @(posedge clk);
    rd = 1'b1;
    @(posedge clk);
    rd = 1'b0;
  endtask

  task automatic idle(input int bits);
    line = 1'b1;
    repeat (bits * BIT) @(posedge clk);
  endtask

  initial begin
    repeat (5) @(posedge clk);
    chk("rst_dat", rx_dat_o, 32'h0);
    chk("rst_valid", rx_valid_o, 32'h0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    chk("rst_ferr", rx_ferr_o, 32'h0);
    chk("rst_ovr", rx_ovr_o, 32'h0);
    idle(1);

    // Basic frame and the valid latency relative to the stop-bit middle
    ferr_base = ferr_cnt;
    send_byte(8'h55, BIT, 1'b1);
    chk("55_valid", rx_valid_o, 32'h1);
    chk("55_dat", rx_dat_o, 32'h55);
    chk("55_ovr", rx_ovr_o, 32'h0);
    chk("55_lat", (rise_off >= BIT * 7 / 16 - 6 && rise_off <= BIT / 2 + 10) ? 32'h1 : 32'h0, 32'h1);
    pulse_rd();
    chk("55_rd_valid", rx_valid_o, 32'h0);
    chk("55_rd_dat_hold", rx_dat_o, 32'h55);

    // Back-to-back frames with a concurrent reader
    fork
      begin
        send_byte(8'hA5, BIT, 1'b1);
        send_byte(8'h3C, BIT, 1'b1);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          b2b_got = 1'b0;
          for (int c = 0; c < 12 * BIT; c++) begin
            @(posedge clk);
            if (rx_valid_o) begin
              b2b_got = 1'b1;
              break;
            end
          end
          chk("b2b_valid", {31'd0, b2b_got}, 32'h1);
          chk("b2b_dat", rx_dat_o, {24'd0, b2b_exp[k]});
          pulse_rd();
        end
      end
    join
    chk("b2b_empty", rx_valid_o, 32'h0);
    chk("b2b_ferr", ferr_cnt - ferr_base, 32'h0);
    idle(1);

    // Short glitch must be rejected silently
    line = 1'b0;
    repeat (BIT * 300 / 868) @(posedge clk);
    idle(2);
    chk("glitch_valid", rx_valid_o, 32'h0);
    chk("glitch_ferr", ferr_cnt - ferr_base, 32'h0);
    send_byte(8'h81, BIT, 1'b1);
    chk("81_valid", rx_valid_o, 32'h1);
    chk("81_dat", rx_dat_o, 32'h81);
    pulse_rd();
    idle(1);

    // Framing error followed by a stuck-low line
    send_byte(8'h0F, BIT, 1'b0);
    line = 1'b0;
    repeat (20 * BIT) @(posedge clk);
    chk("ferr_count", ferr_cnt - ferr_base, 32'h1);
    chk("ferr_valid", rx_valid_o, 32'h0);
    idle(1);
    send_byte(8'h7E, BIT, 1'b1);
    chk("7E_dat", rx_dat_o, 32'h7E);
    chk("7E_valid", rx_valid_o, 32'h1);
    chk("7E_ferr", ferr_cnt - ferr_base, 32'h1);
    pulse_rd();
    idle(1);

    // Overrun
`ifdef UART_RX_FIFO_EN
    for (int i = 1; i <= 9; i++) begin
      send_byte(8'(i), BIT, 1'b1);
    end
    chk("ovr_flag", rx_ovr_o, 32'h1);
    for (int i = 1; i <= 8; i++) begin
      chk("fifo_valid", rx_valid_o, 32'h1);
      chk("fifo_dat", rx_dat_o, 32'(i));
      pulse_rd();
      chk("fifo_ovr_clr", rx_ovr_o, 32'h0);
    end
    chk("fifo_empty", rx_valid_o, 32'h0);
`else
    send_byte(8'h11, BIT, 1'b1);
    chk("ovr_pre", rx_ovr_o, 32'h0);
    send_byte(8'h22, BIT, 1'b1);
    chk("ovr_dat", rx_dat_o, 32'h11);
    chk("ovr_flag", rx_ovr_o, 32'h1);
    chk("ovr_valid", rx_valid_o, 32'h1);
    pulse_rd();
    chk("ovr_clr", rx_ovr_o, 32'h0);
    chk("ovr_rd_valid", rx_valid_o, 32'h0);
`endif
    idle(1);

    // Reset in the middle of bit 4 with a byte already buffered
    send_byte(8'h66, BIT, 1'b1);
    chk("66_valid", rx_valid_o, 32'h1);
    fork
      send_byte(8'hC3, BIT, 1'b1);
      begin
        repeat (BIT * 11 / 2) @(posedge clk);
        rst = 1'b1;
        #2;
        chk("mid_rst_dat", rx_dat_o, 32'h0);
        chk("mid_rst_valid", rx_valid_o, 32'h0);
        chk("mid_rst_ovr", rx_ovr_o, 32'h0);
        chk("mid_rst_ferr", rx_ferr_o, 32'h0);
      end
    join
    @(posedge clk);
    rst = 1'b0;
    idle(2);
    chk("post_rst_valid", rx_valid_o, 32'h0);
    send_byte(8'h5A, BIT, 1'b1);
    chk("5A_dat", rx_dat_o, 32'h5A);
    chk("5A_valid", rx_valid_o, 32'h1);
    pulse_rd();
    idle(1);

    // Sender baud error of +3% and -3%
    ferr_base = ferr_cnt;
    send_byte(8'hC3, BIT_HI, 1'b1);
    chk("fast_dat", rx_dat_o, 32'hC3);
    chk("fast_valid", rx_valid_o, 32'h1);
    pulse_rd();
    idle(1);
    send_byte(8'h3C, BIT_LO, 1'b1);
    repeat (BIT / 4) @(posedge clk);
    chk("slow_dat", rx_dat_o, 32'h3C);
    chk("slow_valid", rx_valid_o, 32'h1);
    chk("tol_ferr", ferr_cnt - ferr_base, 32'h0);
    pulse_rd();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the console link: the counterpart of the existing 8N1 transmitter, using the same 115200-baud framing from the 100 MHz system clock.
- Oversamples uart_rx_i at 16x baud, validates start/stop bits and delivers bytes through a valid/read handshake to the processor's I/O register block.
- Sits between the board RX pin and the memory-mapped UART data/status registers.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- FIFO_DEPTH, 8, receive FIFO entries. Power of 2, ≥2. Used only when UART_RX_FIFO_EN is defined.

Ports:
- sys_clk_i  input  1  system clock. All flops update on its falling edge.
- sys_rst_i  input  1  reset; asynchronous, active-high.
- uart_rx_i  input  1  asynchronous serial line; idle high.
- rx_rd_i  input  1  one-cycle pulse; consumes the byte currently on rx_dat_o.
- rx_dat_o  output  8  received byte (head of buffer).
- rx_valid_o  output  1  high while at least one unread byte is buffered.
- rx_ferr_o  output  1  one-cycle pulse on a framing error.
- rx_ovr_o  output  1  sticky overrun flag; cleared by rx_rd_i.

Behaviour:
- Reset values: rx_dat_o=0, rx_valid_o=0, rx_ferr_o=0, rx_ovr_o=0. FSM=IDLE; accumulator, synchronizer and buffer cleared. Synchronizer flops reset to 1.
- Input path: 2-flop synchronizer on uart_rx_i. All decisions use the synchronized value rxs.
- Tick generator:
  - 32-bit free-running accumulator: acc += BAUD*16 each cycle.
  - When acc+BAUD*16 ≥ CLK_HZ: subtract CLK_HZ and assert tick for 1 cycle.
  - Average tick rate is 1,843,200 Hz (one tick per ~54.25 clocks).
- FSM (advances only on tick, except IDLE start detection):
  - IDLE: on rxs=0, cnt=0 → START.
  - START: on the 8th tick (mid start bit), rxs=0 → DATA with cnt=0, bit=0. rxs=1 → IDLE (glitch rejected, nothing reported).
  - DATA: every 16th tick, sample rxs into shift[bit], LSB first. After bit 7 → STOP.
  - STOP: 16th tick samples the stop bit.
    - rxs=1: push byte into buffer → IDLE.
    - rxs=0: pulse rx_ferr_o, discard byte → WAIT_HIGH.
  - WAIT_HIGH: remain until rxs=1 (break / stuck-low line), then → IDLE. A new start is never detected while in WAIT_HIGH.
- Buffer without FIFO: one holding register.
  - Push when empty: load rx_dat_o, set rx_valid_o the next cycle.
  - rx_rd_i while valid: clear rx_valid_o next cycle. rx_dat_o holds its last value.
  - rx_rd_i while not valid is ignored.
- Overrun: push while full with no rx_rd_i in the same cycle → new byte dropped, old data kept, rx_ovr_o=1. rx_ovr_o stays set until the next rx_rd_i.
- Simultaneous push and rx_rd_i while full: old byte consumed, new byte loaded, rx_valid_o stays 1, no overrun.
- Latency: rx_valid_o rises one clock after the stop-bit sample tick.
- Reset mid-frame: FSM returns to IDLE immediately and the partial byte is lost.
  - After release, if the line is low mid-frame, the FSM may resync on a data bit.
  - That frame either yields garbage or a framing error. This is acceptable; the spec makes no guarantee there.
- Tolerance: must receive correctly with sender baud error up to ±3%.

Optional Feature:
- Macro: UART_RX_FIFO_EN.
- Defined:
  - The holding register is replaced by a FIFO_DEPTH-entry circular FIFO with log2(FIFO_DEPTH)+1-bit read/write pointers.
  - rx_dat_o is the head entry (combinational from storage); rx_valid_o = not empty.
  - Overrun occurs only when full; the same simultaneous push/read rule applies.
  - Pointers wrap modulo FIFO_DEPTH.
- Undefined: depth-1 holding register as described in Behaviour. The FIFO_DEPTH parameter is ignored.

Test Plan:
- Bit period 868 clocks. Send 0x55, 8N1 → rx_valid_o=1 with rx_dat_o=0x55 within 1 clock after mid stop bit; rx_ferr_o=0, rx_ovr_o=0. Pulse rx_rd_i → rx_valid_o=0.
- Back-to-back 0xA5, 0x3C with no idle gap, rx_rd_i after each → both bytes received in order; no errors.
- 300-clock low glitch on idle line → no rx_valid_o, no rx_ferr_o; FSM back in IDLE. A following 0x81 is received correctly.
- Frame 0x0F with stop bit held low, then line low for 20 bit times → exactly one rx_ferr_o pulse and no byte. Then 0x7E is received correctly after the line returns high.
- Without FIFO: send 0x11, 0x22 with no read → rx_dat_o=0x11, rx_ovr_o=1. rx_rd_i clears rx_ovr_o and rx_valid_o. With UART_RX_FIFO_EN: 9 bytes 0x01..0x09 unread → 8 bytes buffered, rx_ovr_o=1; reads return 0x01..0x08.
- Assert sys_rst_i during bit 4 of 0xC3 → all outputs 0 immediately. After release and an idle line, 0x5A is received correctly. Also run 0xC3 with the sender at +3% and −3% baud → received correctly.
